deserializer: RTL and testbench
===============================

# deserializer

Serial-to-parallel converter: collects single bits qualified by `data_val_i` and emits one 16-bit word with a one-cycle valid strobe after every 16th accepted bit. It sits between a bit-serial source (line receiver, shift-out peripheral) and word-oriented downstream logic on the same clock. Bits need not be contiguous; gaps in `data_val_i` only pause accumulation.

## Interface
- `DATA_W`, default 16: output word width; must be ≥ 2.
- `clk_i`  in  1  single system clock; all logic on its rising edge.
- `srst_i`  in  1  reset, asynchronous, active-high. Assertion clears state immediately. Deassertion takes effect at the next rising clock edge.
- `data_i`  in  1  serial data bit; sampled only when `data_val_i`=1.
- `data_val_i`  in  1  qualifies `data_i` on this edge.
- `deser_data_o`  out  DATA_W  assembled word, MSB = first received bit.
- `deser_data_val_o`  out  1  one-cycle strobe: `deser_data_o` holds a complete new word.

## Operation
- Internal shift register `shreg[DATA_W-1:0]` and bit counter `cnt` (0..DATA_W-1, width $clog2(DATA_W)).
- On an edge with `data_val_i`=1:
  - shift in MSB-first: `shreg <= {shreg[DATA_W-2:0], data_i}`.
  - if `cnt` = DATA_W-1: counter wraps to 0; the completed word `{shreg[DATA_W-2:0], data_i}` loads into the `deser_data_o` register; `deser_data_val_o` is set to 1.
  - otherwise `cnt` increments.
- On an edge with `data_val_i`=0: shreg and cnt hold; `data_i` is ignored (X tolerated).
- `deser_data_val_o` is 0 on every edge that does not complete a word.
- `deser_data_o` holds the last completed word until the next completion; it does not follow shreg.
- No partial-word flush. A word is emitted only after exactly DATA_W accepted bits.
- Reset (`srst_i`=1, any time, including mid-word): cnt=0, shreg=0, `deser_data_o`=0, `deser_data_val_o`=0. Any partially collected bits are discarded.
- X on `data_val_i` outside reset is illegal. Bench asserts `data_val_i` is known after reset.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Latency: the 16th accepted bit is sampled at edge N; `deser_data_val_o`=1 and the new word are visible after edge N, for exactly one cycle.
- Back-to-back words with continuous `data_val_i`: a strobe every 16 cycles. Bit 0 of the next word may arrive on the cycle right after the completing bit, with no bubble.
- Throughput: one bit per clock maximum.
- Gaps of any length (including across an in-progress word) do not lose bits.
- Reset values: `deser_data_o`=0, `deser_data_val_o`=0.

## Structure
- Package `deserializer_pkg`: `DATA_W` default (16) and `CNT_W = $clog2(DATA_W)`. The module imports it for parameter defaults.
- Single flat module, with one `always_ff` for the counter/shift register and one for the output registers. No sub-module needed.

## Test plan
- Reset: pulse `srst_i` for one cycle, including asynchronously mid-cycle -> outputs 0 immediately; strobe stays 0 with `data_val_i`=0.
- Continuous word: `data_val_i`=1, `data_i`=1 for 16 cycles -> one strobe with 0xFFFF. Then 16 zeros -> one strobe with 0x0000, exactly 16 cycles later.
- Bit order: continuous 1111 0000 1111 0000 -> 0xF0F0 (first bit at bit 15).
- Gapped input: `data_val_i`=0 for 16 cycles -> no strobe. Then 4 valid zeros, 8 invalid cycles with `data_i`=1, then 12 valid ones -> single strobe with 0x0FFF, one cycle after the last valid bit.
- Mid-word reset: 10 valid ones, async reset, then 16 valid zeros -> exactly one strobe with 0x0000. No strobe counted from the pre-reset bits.
- Hold: after a strobe, keep `data_val_i`=0 for 20 cycles -> `deser_data_o` unchanged and strobe stays 0.

Source files
------------

// File: rtl/deserializer_pkg.sv
// Shared defaults for the bit-serial to word deserializer.
package deserializer_pkg;

    localparam int DESER_DATA_W = 16;
    localparam int DESER_CNT_W  = $clog2(DESER_DATA_W);

endpackage

// File: rtl/deserializer.sv
// Serial-to-parallel converter: MSB-first bits qualified by data_val_i are
// packed into DATA_W-bit words, each announced with a one-cycle strobe.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int DATA_W = DESER_DATA_W
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              data_i,
    input  logic              data_val_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic              deser_data_val_o
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic              last_bit;
    logic [DATA_W-1:0] next_word;

    assign last_bit  = (cnt == CNT_W'(DATA_W - 1));
    assign next_word = {shreg[DATA_W-2:0], data_i};

    // Accumulation: idle cycles freeze both the partial word and the bit count
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (data_val_i) begin
            shreg <= next_word;
            cnt   <= last_bit ? '0 : cnt + CNT_W'(1);
        end
    end

    // Output stage: the word register only changes on completion, not with shreg
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            deser_data_o     <= '0;
            deser_data_val_o <= 1'b0;
        end else begin
            deser_data_val_o <= data_val_i && last_bit;
            if (data_val_i && last_bit) begin
                deser_data_o <= next_word;
            end
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Randomized and directed bench for deserializer against a bit-queue model.
module tb_deserializer;

    localparam int DATA_W = 16;

    logic              clk;
    logic              srst_i;
    logic              data_i;
    logic              data_val_i;
    logic [DATA_W-1:0] deser_data_o;
    logic              deser_data_val_o;

    deserializer #(.DATA_W(DATA_W)) dut (
        .clk_i            (clk),
        .srst_i           (srst_i),
        .data_i           (data_i),
        .data_val_i       (data_val_i),
        .deser_data_o     (deser_data_o),
        .deser_data_val_o (deser_data_val_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_strobe = 0;
    bit chk_en = 1'b0;

    // Reference model: accepted bits queued in arrival order
    bit                bits_q[$];
    logic [DATA_W-1:0] exp_word = '0;
    logic              exp_val  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic model_reset();
        bits_q.delete();
        exp_word = '0;
        exp_val  = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic d);
        logic [DATA_W-1:0] w;
        if (srst_i) begin
            model_reset();
            return;
        end
        exp_val = 1'b0;
        if (v) begin
            bits_q.push_back(d);
            if (bits_q.size() == DATA_W) begin
                w = '0;
                foreach (bits_q[i]) w = (w << 1) | DATA_W'(bits_q[i]);
                exp_word = w;
                exp_val  = 1'b1;
                bits_q.delete();
            end
        end
    endtask

    // One clock: drive at the falling edge, model at the rising edge
    task automatic step(input logic v, input logic d);
        data_val_i = v;
        data_i     = d;
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
        if (deser_data_val_o) n_strobe++;
    endtask

    task automatic async_reset();
        #2;
        srst_i = 1'b1;
        #1;
        check("async_rst_data", 32'(deser_data_o), 32'h0);
        check("async_rst_val", 32'(deser_data_val_o), 32'h0);
        model_reset();
        step(1'b0, 1'b0);
        srst_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_val", 32'(deser_data_val_o), 32'(exp_val));
            check("cyc_data", 32'(deser_data_o), 32'(exp_word));
        end
    end

    always @(posedge clk) begin
        if (!srst_i) begin
            assert (!$isunknown(data_val_i)) else $error("data_val_i unknown");
        end
    end

    initial begin
        logic [DATA_W-1:0] pat;
        int                s0;
        srst_i     = 1'b1;
        data_i     = 1'b0;
        data_val_i = 1'b0;
        @(negedge clk);
        step(1'b0, 1'b0);
        chk_en = 1'b1;
        step(1'b0, 1'b0);
        check("reset_data", 32'(deser_data_o), 32'h0);
        check("reset_val", 32'(deser_data_val_o), 32'h0);
        srst_i = 1'b0;
        repeat (3) step(1'b0, 1'b1);
        check("idle_no_strobe", 32'(n_strobe), 32'd0);

        for (int i = 0; i < DATA_W; i++) step(1'b1, 1'b1);
        check("ones_val", 32'(deser_data_val_o), 32'h1);
        check("ones_word", 32'(deser_data_o), 32'hFFFF);
        for (int i = 0; i < DATA_W - 1; i++) step(1'b1, 1'b0);
        check("zeros_not_early", 32'(deser_data_val_o), 32'h0);
        check("zeros_hold_prev", 32'(deser_data_o), 32'hFFFF);
        step(1'b1, 1'b0);
        check("zeros_val", 32'(deser_data_val_o), 32'h1);
        check("zeros_word", 32'(deser_data_o), 32'h0000);

        pat = 16'hF0F0;
        for (int i = DATA_W - 1; i >= 0; i--) step(1'b1, pat[i]);
        check("order_word", 32'(deser_data_o), 32'hF0F0);
        check("order_model", 32'(exp_word), 32'hF0F0);

        s0 = n_strobe;
        for (int i = 0; i < DATA_W; i++) step(1'b0, 1'b1);
        check("gap_no_strobe", 32'(n_strobe - s0), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
        check("gap_val", 32'(deser_data_val_o), 32'h1);
        check("gap_word", 32'(deser_data_o), 32'h0FFF);
        check("gap_one_strobe", 32'(n_strobe - s0), 32'd1);

        s0 = n_strobe;
        for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom));
        check("hold_word", 32'(deser_data_o), 32'h0FFF);
        check("hold_no_strobe", 32'(n_strobe - s0), 32'd0);

        for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
        async_reset();
        s0 = n_strobe;
        for (int i = 0; i < DATA_W; i++) step(1'b1, 1'b0);
        check("midrst_strobes", 32'(n_strobe - s0), 32'd1);
        check("midrst_word", 32'(deser_data_o), 32'h0000);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) async_reset();
            else step(1'($urandom_range(0, 2) != 0), 1'($urandom));
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
